// File: rtl/cpu_controller.sv
// Instruction register, field decoder and control FSM for the datapath.
// The IR is latched only while idle. Moore outputs decode from the state and the IR.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetA,
    StGetB,
    StAlu,
    StWriteReg
  } state_e;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;

  localparam logic [3:0] VselMdata  = 4'b0001;
  localparam logic [3:0] VselSximm8 = 4'b0010;
  localparam logic [3:0] VselC      = 4'b1000;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

  logic is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_alu;

  assign is_mov_imm = (opcode == OpcMov) && (op == 2'b10);
  assign is_mov_reg = (opcode == OpcMov) && (op == 2'b00);
  assign is_alu     = (opcode == OpcAlu);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);

  // IR captures a new instruction only while idle in WAIT.
  always_comb begin
    ir_d = ir_q;
    if (load && (state_q == StWait)) ir_d = in;
  end

  // State and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    vsel     = 4'b0000;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = sh;
    ALUop    = 2'b00;

    unique case (state_q)
      StWait: begin
        w = 1'b1;
        if (s) state_d = StDecode;
      end
      StDecode: begin
        // Unsupported encodings fall straight back to WAIT with no side effects.
        if (is_mov_imm)                state_d = StWriteImm;
        else if (is_mov_reg || is_mvn) state_d = StGetB;
        else if (is_alu)               state_d = StGetA;
        else                           state_d = StWait;
      end
      StWriteImm: begin
        writenum = rn;
        vsel     = VselSximm8;
        write    = 1'b1;
        state_d  = StWait;
      end
      StGetA: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = StGetB;
      end
      StGetB: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = StAlu;
      end
      StAlu: begin
        // MOV reg passes B through the adder with A forced to zero.
        if (is_mov_reg) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = op;
        end
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = StWait;
        end else begin
          loadc   = 1'b1;
          state_d = StWriteReg;
        end
      end
      StWriteReg: begin
        writenum = rd;
        vsel     = VselC;
        write    = 1'b1;
        state_d  = StWait;
      end
      default: state_d = StWait;
    endcase

    // Reset suppresses every datapath enable immediately, whatever the state.
    if (reset) begin
      write = 1'b0;
      loada = 1'b0;
      loadb = 1'b0;
      loadc = 1'b0;
      loads = 1'b0;
    end
  end

  logic unused_vsel_mdata;
  assign unused_vsel_mdata = ^VselMdata;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: steps through each instruction class state by state.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int checks = 0;
  int errors = 0;

  cpu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .load     (load),
    .in       (in),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enables packed as {write, loada, loadb, loadc, loads}.
  function automatic logic [4:0] en();
    return {write, loada, loadb, loadc, loads};
  endfunction

  task automatic load_ir(input logic [15:0] instr);
    in = instr; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    tick();
    reset = 1'b0;
    chk("rst_w", 16'(w), 16'h1);
    chk("rst_en", 16'(en()), 16'h0);
    chk("rst_sximm8", sximm8, 16'h0000);
    chk("rst_vsel", 16'(vsel), 16'h0);

    // 1: MOV R0,#7
    load_ir(16'hD007);
    chk("t1_wait_w", 16'(w), 16'h1);
    chk("t1_sximm8", sximm8, 16'h0007);
    s = 1'b1; tick(); s = 1'b0;
    chk("t1_dec_w", 16'(w), 16'h0);
    chk("t1_dec_en", 16'(en()), 16'h0);
    tick();
    chk("t1_wi_en", 16'(en()), 16'b10000);
    chk("t1_wi_writenum", 16'(writenum), 16'h0);
    chk("t1_wi_vsel", 16'(vsel), 16'b0010);
    chk("t1_wi_w", 16'(w), 16'h0);
    tick();
    chk("t1_done_w", 16'(w), 16'h1);
    chk("t1_done_en", 16'(en()), 16'h0);

    // 2: MOV R1,#-2
    load_ir(16'hD1FE);
    chk("t2_sximm8", sximm8, 16'hFFFE);
    chk("t2_sximm5", sximm5, 16'hFFFE);
    s = 1'b1; tick(); s = 1'b0;
    tick();
    chk("t2_wi_writenum", 16'(writenum), 16'h1);
    chk("t2_wi_write", 16'(write), 16'h1);
    tick();
    chk("t2_done_w", 16'(w), 16'h1);

    // 3: ADD R2,R1,R0,LSL#1 with load and s together; load ignored during ALU
    in = 16'hA148; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
    chk("t3_dec_w", 16'(w), 16'h0);
    chk("t3_sximm8", sximm8, 16'h0048);
    chk("t3_sximm5", sximm5, 16'h0008);
    tick();
    chk("t3_ga_readnum", 16'(readnum), 16'h1);
    chk("t3_ga_en", 16'(en()), 16'b01000);
    tick();
    chk("t3_gb_readnum", 16'(readnum), 16'h0);
    chk("t3_gb_en", 16'(en()), 16'b00100);
    tick();
    chk("t3_alu_aluop", 16'(ALUop), 16'h0);
    chk("t3_alu_shift", 16'(shift), 16'h1);
    chk("t3_alu_en", 16'(en()), 16'b00010);
    chk("t3_alu_asel", 16'(asel), 16'h0);
    chk("t3_alu_bsel", 16'(bsel), 16'h0);
    in = 16'hFFFF; load = 1'b1;
    tick();
    load = 1'b0;
    chk("t3_wr_writenum", 16'(writenum), 16'h2);
    chk("t3_wr_vsel", 16'(vsel), 16'b1000);
    chk("t3_wr_en", 16'(en()), 16'b10000);
    chk("t3_ir_kept", sximm8, 16'h0048);
    tick();
    chk("t3_done_w", 16'(w), 16'h1);
    chk("t3_ir_kept2", sximm8, 16'h0048);

    // 4: CMP R1,R0 with s held high throughout; re-executes after returning to WAIT
    load_ir(16'hA900);
    s = 1'b1;
    tick();
    chk("t4_dec_w", 16'(w), 16'h0);
    tick();
    chk("t4_ga_readnum", 16'(readnum), 16'h1);
    chk("t4_ga_write", 16'(write), 16'h0);
    tick();
    chk("t4_gb_loadb", 16'(loadb), 16'h1);
    chk("t4_gb_write", 16'(write), 16'h0);
    tick();
    chk("t4_alu_en", 16'(en()), 16'b00001);
    chk("t4_alu_aluop", 16'(ALUop), 16'h1);
    tick();
    chk("t4_done_w", 16'(w), 16'h1);
    chk("t4_done_write", 16'(write), 16'h0);
    tick();
    s = 1'b0;
    chk("t4_restart_w", 16'(w), 16'h0);
    tick();
    chk("t4_restart_loada", 16'(loada), 16'h1);
    tick(); tick(); tick();
    chk("t4_restart_done", 16'(w), 16'h1);

    // 5: MOV R3,R0 skips GET_A
    load_ir(16'hC060);
    s = 1'b1; tick(); s = 1'b0;
    tick();
    chk("t5_gb_en", 16'(en()), 16'b00100);
    chk("t5_gb_readnum", 16'(readnum), 16'h0);
    tick();
    chk("t5_alu_asel", 16'(asel), 16'h1);
    chk("t5_alu_aluop", 16'(ALUop), 16'h0);
    chk("t5_alu_en", 16'(en()), 16'b00010);
    tick();
    chk("t5_wr_writenum", 16'(writenum), 16'h3);
    chk("t5_wr_vsel", 16'(vsel), 16'b1000);
    tick();
    chk("t5_done_w", 16'(w), 16'h1);

    // MVN R7,R1
    load_ir(16'hB8E1);
    s = 1'b1; tick(); s = 1'b0;
    tick();
    chk("mvn_gb_readnum", 16'(readnum), 16'h1);
    chk("mvn_gb_en", 16'(en()), 16'b00100);
    tick();
    chk("mvn_alu_aluop", 16'(ALUop), 16'h3);
    chk("mvn_alu_asel", 16'(asel), 16'h0);
    tick();
    chk("mvn_wr_writenum", 16'(writenum), 16'h7);
    tick();
    chk("mvn_done_w", 16'(w), 16'h1);

    // Unsupported opcode returns to WAIT straight from DECODE
    load_ir(16'h6000);
    s = 1'b1; tick(); s = 1'b0;
    chk("bad_dec_w", 16'(w), 16'h0);
    tick();
    chk("bad_done_w", 16'(w), 16'h1);
    chk("bad_done_en", 16'(en()), 16'h0);

    // 6: reset asserted in GET_B of an ADD
    load_ir(16'hA148);
    s = 1'b1; tick(); s = 1'b0;
    tick();
    tick();
    chk("t6_gb_loadb", 16'(loadb), 16'h1);
    reset = 1'b1;
    #1;
    chk("t6_rst_en", 16'(en()), 16'h0);
    tick();
    reset = 1'b0;
    chk("t6_after_w", 16'(w), 16'h1);
    chk("t6_after_ir", sximm8, 16'h0000);
    chk("t6_after_sximm5", sximm5, 16'h0000);
    chk("t6_after_en", 16'(en()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Instruction register, decoder and control FSM sitting directly upstream of the datapath; it drives every datapath control input.
- Latches a 16-bit instruction.
- Decodes register numbers, shift code and sign-extended immediates from it.
- Sequences the datapath through read / ALU / writeback states, one state per clock.
- Signals completion on w.

Parameters:
None.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
s  input  1  start execution of the latched instruction
load  input  1  latch in into the instruction register (IR)
in  input  16  instruction word
w  output  1  1 = idle in WAIT, ready for load/s
readnum  output  3  register file read address
writenum  output  3  register file write address
write  output  1  register file write enable
vsel  output  4  writeback select, one-hot: 0001 mdata, 0010 sximm8, 0100 PC, 1000 C
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status register
asel  output  1  1 = ALU A input forced to 0
bsel  output  1  1 = ALU B input from sximm5
shift  output  2  shifter code
ALUop  output  2  00 add, 01 sub, 10 and, 11 not B
sximm8  output  16  IR[7:0] sign-extended
sximm5  output  16  IR[4:0] sign-extended

Behaviour:
- Reset:
  - Synchronous, active-high; one clock edge with reset=1 sets state=WAIT and IR=16'h0000.
  - While reset=1, write/loada/loadb/loadc/loads are forced 0 combinationally, in any state.
- IR:
  - Fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
  - IR<=in on an edge with load=1 and state=WAIT only; load is ignored in every other state.
- Supported instructions:
  - MOV Rn,#im8: opcode 110, op 10.
  - MOV Rd,Rm{,sh}: opcode 110, op 00.
  - ADD / CMP / AND / MVN: opcode 101, op 00 / 01 / 10 / 11.
- FSM (Moore; outputs are decoded from state + IR):
  - WAIT: w=1, all enables 0. s=1 -> DECODE, else stay.
  - DECODE: all enables 0. Next state:
    - MOV imm -> WRITE_IMM.
    - MOV reg or MVN -> GET_B.
    - ADD/CMP/AND -> GET_A.
    - Any other opcode/op -> WAIT (no register or status change).
  - WRITE_IMM: writenum=Rn, vsel=0010, write=1 -> WAIT.
  - GET_A: readnum=Rn, loada=1 -> GET_B.
  - GET_B: readnum=Rm, loadb=1 -> ALU.
  - ALU:
    - shift=sh; bsel=0.
    - MOV reg: asel=1, ALUop=00.
    - Otherwise: asel=0, ALUop=op.
    - CMP: loads=1, loadc=0 -> WAIT.
    - All others: loadc=1, loads=0 -> WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=1000, write=1 -> WAIT.
- Output defaults:
  - readnum/writenum = 3'b000 outside the states above.
  - vsel = 0000 outside write states.
  - shift = sh in every state; asel=0, bsel=0 unless stated.
- w=1 exactly in WAIT, 0 otherwise.
- Latency, in edges from the s-sampling edge back to WAIT:
  - MOV imm: 2.
  - MOV reg / MVN / CMP: 4.
  - ADD / AND: 5.
- sximm8 and sximm5 are combinational from IR, valid in every state.
- Boundary conditions:
  - s and load both high in WAIT: IR takes the new in and state goes to DECODE; the new instruction executes.
  - s held high continuously: a new execution starts on the edge after returning to WAIT.
  - s while not in WAIT: ignored.
  - reset mid-instruction: no further enable pulses; WAIT and IR=0 after the edge.

Test Plan:
1. load in=16'hD007, then s -> DECODE, then WRITE_IMM with write=1, writenum=0, vsel=0010, sximm8=16'h0007; w=1 two edges after s.
2. in=16'hD1FE (MOV R1,#-2) -> sximm8=16'hFFFE, sximm5=16'hFFFE; WRITE_IMM has writenum=1.
3. in=16'hA148 (ADD R2,R1,R0,LSL#1) -> sequence:
   - GET_A: readnum=1, loada=1.
   - GET_B: readnum=0, loadb=1.
   - ALU: ALUop=00, shift=01, loadc=1.
   - WRITE_REG: writenum=2, vsel=1000, write=1.
   - w=1 after 5 edges.
4. in=16'hA900 (CMP R1,R0) -> ALU state: loads=1, loadc=0, ALUop=01; write never asserted; w=1 after 4 edges.
5. in=16'hC060 (MOV R3,R0) -> GET_A skipped; ALU: asel=1, ALUop=00; WRITE_REG: writenum=3.
6. Start 16'hA148, assert reset in GET_B -> write/loadb=0 that cycle; next cycle w=1, IR=0. Separately, load=1 with in=16'hFFFF during ALU state -> IR unchanged.
